// File: rtl/rsa_pkg.sv
// Shared key-datapath definitions for the RSA key-derivation blocks.
package rsa_pkg;

  localparam int KEY_W = 12;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    CHECK   = 3'd1,
    DIV     = 3'd2,
    UPDATE  = 3'd3,
    RESOLVE = 3'd4,
    FIN     = 3'd5
  } state_t;

endpackage

// File: rtl/mod_inverse_div.sv
// Restoring shift/subtract divider: one quotient bit per cycle, W cycles.
// The caller guarantees divisor != 0. Outputs hold after done until the next start.
module seq_divider #(
  parameter int W = 12
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] dividend,
  input  logic [W-1:0] divisor,
  output logic [W-1:0] quotient,
  output logic [W-1:0] remainder,
  output logic         done
);

  localparam int CW = $clog2(W + 1);

  logic [W-1:0]  dvs;
  logic [CW-1:0] cnt;
  logic [W:0]    trial;

  // Partial remainder shifted left with the next dividend bit brought in.
  assign trial = {remainder, quotient[W-1]};

  // Load on start, then one restoring step per cycle; done pulses after the last step.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      quotient  <= '0;
      remainder <= '0;
      dvs       <= '0;
      cnt       <= '0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        quotient  <= dividend;
        remainder <= '0;
        dvs       <= divisor;
        cnt       <= CW'(W);
      end else if (cnt != '0) begin
        if (trial >= {1'b0, dvs}) begin
          remainder <= W'(trial - {1'b0, dvs});
          quotient  <= {quotient[W-2:0], 1'b1};
        end else begin
          remainder <= trial[W-1:0];
          quotient  <= {quotient[W-2:0], 1'b0};
        end
        cnt <= cnt - 1'b1;
        if (cnt == CW'(1)) done <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/mod_inverse.sv
// Extended-Euclid modular inverse: inv = e^-1 mod phi, one division per step.
// Flags no_inv when phi < 2, e == 0, or gcd(e, phi) != 1.
module mod_inverse
  import rsa_pkg::*;
#(
  parameter int W  = KEY_W,
  parameter int TW = W + 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] e,
  input  logic [W-1:0] phi,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] inv,
  output logic         no_inv
);

  state_t state, nxt;

  logic [W-1:0]         r0, r1, q, rem_r, phi_r;
  logic signed [TW-1:0] t0, t1;
  logic                 bad_in;
  logic                 accept;
  logic                 div_start, div_done;
  logic [W-1:0]         div_q, div_r;

  // New requests are taken only when idle or on the done cycle (back-to-back).
  assign accept = start && (state == IDLE || state == FIN);
  assign busy   = (state != IDLE) && (state != FIN);
  assign done   = (state == FIN);

  seq_divider #(.W(W)) u_div (
    .clk       (clk),
    .rst       (rst),
    .start     (div_start),
    .dividend  (r0),
    .divisor   (r1),
    .quotient  (div_q),
    .remainder (div_r),
    .done      (div_done)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= nxt;
  end

  // Next-state logic and divider launch.
  always_comb begin
    nxt       = state;
    div_start = 1'b0;
    case (state)
      IDLE:    if (start) nxt = CHECK;
      CHECK: begin
        if (bad_in)          nxt = FIN;
        else if (r1 == '0)   nxt = RESOLVE;
        else begin
          div_start = 1'b1;
          nxt       = DIV;
        end
      end
      DIV:     if (div_done) nxt = UPDATE;
      UPDATE:  nxt = CHECK;
      RESOLVE: nxt = FIN;
      FIN:     nxt = start ? CHECK : IDLE;
      default: nxt = IDLE;
    endcase
  end

  // Euclid remainders, Bezout coefficient of e, and result registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r0     <= '0;
      r1     <= '0;
      q      <= '0;
      rem_r  <= '0;
      phi_r  <= '0;
      t0     <= '0;
      t1     <= '0;
      bad_in <= 1'b0;
      inv    <= '0;
      no_inv <= 1'b0;
    end else if (accept) begin
      r0     <= phi;
      r1     <= e;
      phi_r  <= phi;
      t0     <= '0;
      t1     <= TW'(1);
      bad_in <= (phi < W'(2)) || (e == '0);
      inv    <= '0;
      no_inv <= 1'b0;
    end else begin
      case (state)
        CHECK: if (bad_in) no_inv <= 1'b1;
        DIV: if (div_done) begin
          q     <= div_q;
          rem_r <= div_r;
        end
        UPDATE: begin
          r0 <= r1;
          r1 <= rem_r;
          t0 <= t1;
          // Only the low TW bits matter; the true coefficient stays within +-phi.
          t1 <= TW'(t0 - $signed({1'b0, q}) * t1);
        end
        RESOLVE: begin
          if (r0 != W'(1)) begin
            no_inv <= 1'b1;
            inv    <= '0;
          end else begin
            inv <= W'(t0[TW-1] ? t0 + $signed({{(TW-W){1'b0}}, phi_r}) : t0);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mod_inverse.sv
// Self-checking bench for mod_inverse: directed cases plus a random coprime sweep
// checked against a brute-force inverse search.
module tb_mod_inverse;

  localparam int W = 12;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] e = '0;
  logic [W-1:0] phi = '0;
  logic         busy, done, no_inv;
  logic [W-1:0] inv;

  int total = 0;
  int bad   = 0;

  mod_inverse #(.W(W)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .e      (e),
    .phi    (phi),
    .busy   (busy),
    .done   (done),
    .inv    (inv),
    .no_inv (no_inv)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic int gcd(input int a, input int b);
    int x = a, y = b, t;
    while (y != 0) begin
      t = x % y;
      x = y;
      y = t;
    end
    return x;
  endfunction

  // Reference: the inverse is the unique d in [1,phi-1] with e*d == 1 (mod phi).
  task automatic model(input int ee, input int pp, output int m_inv, output int m_no);
    m_inv = 0;
    m_no  = 1;
    if (pp >= 2 && ee != 0)
      for (int d = 1; d < pp; d++)
        if ((ee * d) % pp == 1) begin
          m_inv = d;
          m_no  = 0;
          break;
        end
  endtask

  // Called at a negedge; issues a one-cycle start and then scrambles the operands.
  task automatic go(input int ee, input int pp);
    e     = W'(ee);
    phi   = W'(pp);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    e     = W'($urandom);
    phi   = W'($urandom);
  endtask

  // Returns at the negedge where done is seen, or after the cycle budget.
  task automatic wait_done(output int lat);
    lat = 1;
    while (!done && lat < 300) begin
      @(negedge clk);
      lat++;
    end
    if (!done) chk("timeout", int'(done), 1);
  endtask

  task automatic run_chk(input string tag, input int ee, input int pp);
    int lat, m_inv, m_no;
    model(ee, pp, m_inv, m_no);
    go(ee, pp);
    chk({tag, "_busy"}, int'(busy), 1);
    wait_done(lat);
    chk({tag, "_inv"}, int'(inv), m_inv);
    chk({tag, "_noinv"}, int'(no_inv), m_no);
    @(negedge clk);
    chk({tag, "_pulse"}, int'(done), 0);
    chk({tag, "_hold"}, int'(inv), m_inv);
  endtask

  initial begin
    int lat, m_inv, m_no, ee, pp;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_inv", int'(inv), 0);
    chk("rst_noinv", int'(no_inv), 0);
    rst = 1'b0;
    @(negedge clk);

    // Textbook RSA key
    go(17, 3120);
    wait_done(lat);
    chk("rsa_inv", int'(inv), 2753);
    chk("rsa_noinv", int'(no_inv), 0);
    chk("rsa_prod", (17 * int'(inv)) % 3120, 1);
    @(negedge clk);

    run_chk("e7", 7, 40);
    chk("e7_const", int'(inv), 23);
    run_chk("e43", 43, 40);
    chk("e43_const", int'(inv), 27);
    run_chk("e1", 1, 40);
    chk("e1_const", int'(inv), 1);
    run_chk("gcd2", 6, 40);
    chk("gcd2_const", int'(no_inv), 1);
    run_chk("eq", 40, 40);

    // Degenerate inputs resolve quickly
    go(0, 40);
    wait_done(lat);
    chk("e0_noinv", int'(no_inv), 1);
    chk("e0_fast", int'(lat <= 4), 1);
    @(negedge clk);
    go(5, 1);
    wait_done(lat);
    chk("phi1_noinv", int'(no_inv), 1);
    chk("phi1_inv", int'(inv), 0);
    chk("phi1_fast", int'(lat <= 4), 1);
    @(negedge clk);

    // Start while busy is ignored
    go(17, 3120);
    repeat (4) @(negedge clk);
    chk("ign_busy", int'(busy), 1);
    e = W'(3); phi = W'(40); start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(lat);
    chk("ign_inv", int'(inv), 2753);
    @(negedge clk);

    // Back-to-back: new start on the done cycle
    go(7, 40);
    wait_done(lat);
    chk("b2b_first", int'(inv), 23);
    go(43, 40);
    chk("b2b_busy", int'(busy), 1);
    wait_done(lat);
    chk("b2b_second", int'(inv), 27);
    @(negedge clk);

    // Asynchronous reset in the middle of a division
    go(17, 3120);
    repeat (3) @(negedge clk);
    chk("mid_busy", int'(busy), 1);
    #2 rst = 1'b1;
    #1;
    chk("arst_busy", int'(busy), 0);
    chk("arst_done", int'(done), 0);
    chk("arst_inv", int'(inv), 0);
    chk("arst_noinv", int'(no_inv), 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    go(7, 40);
    wait_done(lat);
    chk("post_rst_inv", int'(inv), 23);
    @(negedge clk);

    // Random coprime sweep
    for (int n = 0; n < 300; n++) begin
      do begin
        pp = int'($urandom_range(2, 4095));
        ee = int'($urandom_range(1, 4095));
      end while (gcd(ee, pp) != 1);
      model(ee, pp, m_inv, m_no);
      go(ee, pp);
      wait_done(lat);
      chk("rnd_inv", int'(inv), m_inv);
      chk("rnd_noinv", int'(no_inv), m_no);
      chk("rnd_prod", (ee * int'(inv)) % pp, (pp == 1) ? 0 : 1);
      chk("rnd_lat", int'(lat <= 300), 1);
      @(negedge clk);
      chk("rnd_pulse", int'(done), 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
